// File: rtl/trng_ctrl_pkg.sv
// Shared state encoding and von Neumann pair decode constants for the TRNG harvest controller.
package trng_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WARMUP = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_ERROR  = 2'd3
    } state_t;

    // Pairs are written {first, second}; only the unequal pairs yield a bit.
    localparam logic [1:0] VN_PAIR_01 = 2'b01;
    localparam logic [1:0] VN_PAIR_10 = 2'b10;
    localparam logic       VN_BIT_01  = 1'b0;
    localparam logic       VN_BIT_10  = 1'b1;

endpackage

// File: rtl/trng_byte_fifo.sv
// Small synchronous byte FIFO with flush; head reads as 0x00 while empty.
module trng_byte_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       i_push,
    input  logic                       i_pop,
    input  logic                       i_flush,
    input  logic [7:0]                 i_data,
    output logic [7:0]                 o_head,
    output logic [$clog2(DEPTH):0]     o_level,
    output logic                       o_full,
    output logic                       o_empty
);
    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;

    logic [7:0]    r_mem [DEPTH];
    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [LW-1:0] r_level;
    logic          w_do_push;
    logic          w_do_pop;

    assign o_full    = (r_level == LW'(DEPTH));
    assign o_empty   = (r_level == '0);
    assign o_level   = r_level;
    assign o_head    = o_empty ? 8'h00 : r_mem[r_rptr];
    // A pop on a full FIFO frees the slot only; the waiting push lands next cycle.
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
        end else if (i_flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
        end else begin
            if (w_do_push) r_wptr <= r_wptr + PW'(1);
            if (w_do_pop)  r_rptr <= r_rptr + PW'(1);
            case ({w_do_push, w_do_pop})
                2'b10:   r_level <= r_level + LW'(1);
                2'b01:   r_level <= r_level - LW'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_do_push && !i_flush) r_mem[r_wptr] <= i_data;
    end

endmodule

// File: rtl/trng_harvest_ctrl.sv
// Sequences trng_top: warm-up, fixed-rate sampling, XOR fold, optional von Neumann
// debias, byte packing into a FIFO, and a repetition-count health test.
module trng_harvest_ctrl import trng_ctrl_pkg::*; #(
    parameter int WARMUP_CYCLES = 64,
    parameter int SAMPLE_DIV    = 4,
    parameter int RC_LIMIT      = 16,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic                          i_start,
    input  logic                          i_stop,
    input  logic                          i_vn_en,
    input  logic                          i_clr_err,
    input  logic                          i_rd_pop,
    input  logic [7:0]                    i_trng_data,
    output logic                          o_trng_en,
    output logic [7:0]                    o_rnd_data,
    output logic                          o_rnd_valid,
    output logic [$clog2(FIFO_DEPTH):0]   o_fifo_level,
    output logic                          o_busy,
    output logic                          o_health_err
);
    localparam int WW = $clog2(WARMUP_CYCLES + 1);
    localparam int DW = $clog2(SAMPLE_DIV);

    state_t        r_state;
    logic          r_trng_en;
    logic          r_busy;
    logic          r_health_err;
    logic [WW-1:0] r_warm_cnt;
    logic [DW-1:0] r_div;
    logic          r_strobe;
    logic [7:0]    r_rc_cnt;
    logic          r_last_raw;
    logic          r_vn_have;
    logic          r_vn_first;
    logic          r_vn_prev;
    logic [7:0]    r_pack;
    logic [2:0]    r_pack_cnt;
    logic          r_byte_rdy;

    logic          w_full;
    logic          w_empty;
    logic          w_stall;
    logic          w_push;
    logic          w_proc;
    logic          w_raw;
    logic [7:0]    w_rc_next;
    logic          w_trip;
    logic          w_stop;
    logic          w_vn_clr;
    logic          w_vn_have_eff;
    logic [1:0]    w_pair;
    logic          w_bit_en;
    logic          w_bit;

    // A completed byte that cannot enter a full FIFO freezes the divider and health test.
    assign w_stall       = r_byte_rdy && w_full;
    assign w_push        = r_byte_rdy && !w_full;
    assign w_proc        = r_strobe && !r_byte_rdy && (r_state == ST_SAMPLE);
    assign w_raw         = ^i_trng_data;
    assign w_rc_next     = (r_rc_cnt != 8'd0 && w_raw == r_last_raw) ? r_rc_cnt + 8'd1 : 8'd1;
    assign w_trip        = w_proc && (w_rc_next == 8'(RC_LIMIT));
    assign w_stop        = i_stop && (r_state == ST_WARMUP || r_state == ST_SAMPLE);
    assign w_vn_clr      = (i_vn_en != r_vn_prev);
    assign w_vn_have_eff = r_vn_have && !w_vn_clr;
    assign w_pair        = {r_vn_first, w_raw};

    always_comb begin
        w_bit_en = 1'b0;
        w_bit    = w_raw;
        if (w_proc && !w_trip) begin
            if (!i_vn_en) begin
                w_bit_en = 1'b1;
            end else if (w_vn_have_eff) begin
                w_bit_en = (w_pair == VN_PAIR_01) || (w_pair == VN_PAIR_10);
                w_bit    = (w_pair == VN_PAIR_10) ? VN_BIT_10 : VN_BIT_01;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= ST_IDLE;
            r_trng_en    <= 1'b0;
            r_busy       <= 1'b0;
            r_health_err <= 1'b0;
            r_warm_cnt   <= '0;
            r_div        <= '0;
            r_strobe     <= 1'b0;
            r_rc_cnt     <= 8'd0;
            r_last_raw   <= 1'b0;
            r_vn_have    <= 1'b0;
            r_vn_first   <= 1'b0;
            r_vn_prev    <= 1'b0;
            r_pack       <= 8'd0;
            r_pack_cnt   <= 3'd0;
            r_byte_rdy   <= 1'b0;
        end else begin
            r_vn_prev <= i_vn_en;
            r_strobe  <= 1'b0;
            if (w_push) r_byte_rdy <= 1'b0;
            if (w_bit_en) begin
                r_pack     <= {w_bit, r_pack[7:1]};
                r_pack_cnt <= r_pack_cnt + 3'd1;
                if (r_pack_cnt == 3'd7) r_byte_rdy <= 1'b1;
            end
            case (r_state)
                ST_IDLE: begin
                    if (i_start && !i_stop) begin
                        r_state    <= ST_WARMUP;
                        r_warm_cnt <= '0;
                        r_trng_en  <= 1'b1;
                        r_busy     <= 1'b1;
                    end
                end
                ST_WARMUP: begin
                    if (w_stop) begin
                        r_state   <= ST_IDLE;
                        r_trng_en <= 1'b0;
                        r_busy    <= 1'b0;
                    end else if (r_warm_cnt == WW'(WARMUP_CYCLES - 1)) begin
                        r_state <= ST_SAMPLE;
                        r_div   <= '0;
                    end else begin
                        r_warm_cnt <= r_warm_cnt + WW'(1);
                    end
                end
                ST_SAMPLE: begin
                    if (w_stop || w_trip) begin
                        r_state    <= w_stop ? ST_IDLE : ST_ERROR;
                        r_trng_en  <= 1'b0;
                        r_busy     <= 1'b0;
                        r_div      <= '0;
                        r_rc_cnt   <= 8'd0;
                        r_vn_have  <= 1'b0;
                        r_pack_cnt <= 3'd0;
                        r_byte_rdy <= 1'b0;
                        if (!w_stop) r_health_err <= 1'b1;
                    end else begin
                        if (!w_stall) begin
                            r_div    <= (r_div == DW'(SAMPLE_DIV - 1)) ? '0 : r_div + DW'(1);
                            r_strobe <= (r_div == DW'(SAMPLE_DIV - 1));
                        end
                        if (w_vn_clr) r_vn_have <= 1'b0;
                        if (w_proc) begin
                            r_last_raw <= w_raw;
                            r_rc_cnt   <= w_rc_next;
                            if (i_vn_en) begin
                                r_vn_have  <= !w_vn_have_eff;
                                r_vn_first <= w_raw;
                            end
                        end
                    end
                end
                ST_ERROR: begin
                    if (i_clr_err) begin
                        r_state      <= ST_IDLE;
                        r_health_err <= 1'b0;
                    end
                end
            endcase
        end
    end

    trng_byte_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_push  (w_push),
        .i_pop   (i_rd_pop),
        .i_flush (w_trip),
        .i_data  (r_pack),
        .o_head  (o_rnd_data),
        .o_level (o_fifo_level),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign o_rnd_valid  = !w_empty;
    assign o_trng_en    = r_trng_en;
    assign o_busy       = r_busy;
    assign o_health_err = r_health_err;

endmodule

// File: tb/tb_trng_harvest_ctrl.sv
// Directed bench for trng_harvest_ctrl at default parameters (warm-up 64, divider 4, RC 16, depth 4).
module tb_trng_harvest_ctrl;

    localparam logic [7:0] ONE_BYTE  = 8'h0E;
    localparam logic [7:0] ZERO_BYTE = 8'h81;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       stop;
    logic       vn_en;
    logic       clr_err;
    logic       rd_pop;
    logic [7:0] trng_data;
    logic       trng_en;
    logic [7:0] rnd_data;
    logic       rnd_valid;
    logic [2:0] fifo_level;
    logic       busy;
    logic       health_err;

    int checks = 0;
    int errors = 0;
    logic [63:0] streamBits;

    trng_harvest_ctrl dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_start      (start),
        .i_stop       (stop),
        .i_vn_en      (vn_en),
        .i_clr_err    (clr_err),
        .i_rd_pop     (rd_pop),
        .i_trng_data  (trng_data),
        .o_trng_en    (trng_en),
        .o_rnd_data   (rnd_data),
        .o_rnd_valid  (rnd_valid),
        .o_fifo_level (fifo_level),
        .o_busy       (busy),
        .o_health_err (health_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic waitEdges(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic pulseStart();
        start = 1'b1;
        waitEdges(1);
        start = 1'b0;
    endtask

    task automatic pulseStop();
        stop = 1'b1;
        waitEdges(1);
        stop = 1'b0;
    endtask

    task automatic pulsePop();
        rd_pop = 1'b1;
        waitEdges(1);
        rd_pop = 1'b0;
    endtask

    // Entered one cycle after the start edge; each raw bit is held for four cycles
    // centred on the edge that samples it, and the task returns just after the last one.
    task automatic applyStimulus(input int nStrobes);
        waitEdges(67);
        for (int k = 0; k < nStrobes; k++) begin
            if (k > 0) waitEdges(4);
            trng_data = streamBits[k] ? ONE_BYTE : ZERO_BYTE;
        end
        waitEdges(2);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; stop = 1'b0; vn_en = 1'b0;
        clr_err = 1'b0; rd_pop = 1'b0; trng_data = 8'h00; streamBits = '0;
        #23;
        checkOutput("reset_trng_en",   {7'd0, trng_en},    8'h00);
        checkOutput("reset_busy",      {7'd0, busy},       8'h00);
        checkOutput("reset_valid",     {7'd0, rnd_valid},  8'h00);
        checkOutput("reset_level",     {5'd0, fifo_level}, 8'h00);
        checkOutput("reset_health",    {7'd0, health_err}, 8'h00);
        rst_n = 1'b1;
        waitEdges(2);

        start = 1'b1; stop = 1'b1;
        waitEdges(1);
        start = 1'b0; stop = 1'b0;
        waitEdges(1);
        checkOutput("start_stop_same_trng_en", {7'd0, trng_en}, 8'h00);
        checkOutput("start_stop_same_busy",    {7'd0, busy},    8'h00);

        $display("[TB] VN off, alternating bits");
        streamBits = 64'hAA;
        pulseStart();
        checkOutput("start_trng_en", {7'd0, trng_en}, 8'h01);
        checkOutput("start_busy",    {7'd0, busy},    8'h01);
        applyStimulus(8);
        waitEdges(1);
        checkOutput("alt_valid", {7'd0, rnd_valid},  8'h01);
        checkOutput("alt_data",  rnd_data,           8'hAA);
        checkOutput("alt_level", {5'd0, fifo_level}, 8'h01);
        pulseStop();
        checkOutput("alt_stop_busy",  {7'd0, busy},       8'h00);
        checkOutput("alt_stop_level", {5'd0, fifo_level}, 8'h01);

        $display("[TB] VN on, pairs 01,10,00,11,10 repeated");
        vn_en = 1'b1;
        streamBits = 64'h0000_0000_0067_19C6;
        waitEdges(1);
        pulseStart();
        applyStimulus(24);
        waitEdges(1);
        checkOutput("vn_level", {5'd0, fifo_level}, 8'h02);
        checkOutput("vn_head_old", rnd_data, 8'hAA);
        pulseStop();
        pulsePop();
        checkOutput("vn_data",  rnd_data,           8'hB6);
        checkOutput("vn_level_after_pop", {5'd0, fifo_level}, 8'h01);
        pulsePop();
        checkOutput("empty_valid", {7'd0, rnd_valid}, 8'h00);
        checkOutput("empty_data",  rnd_data,          8'h00);
        vn_en = 1'b0;
        waitEdges(1);

        $display("[TB] stuck-at-zero health test");
        trng_data = 8'h00;
        pulseStart();
        waitEdges(125);
        checkOutput("rc15_health", {7'd0, health_err}, 8'h00);
        checkOutput("rc15_busy",   {7'd0, busy},       8'h01);
        checkOutput("rc15_level",  {5'd0, fifo_level}, 8'h01);
        waitEdges(4);
        checkOutput("rc16_health",  {7'd0, health_err}, 8'h01);
        checkOutput("rc16_trng_en", {7'd0, trng_en},    8'h00);
        checkOutput("rc16_busy",    {7'd0, busy},       8'h00);
        checkOutput("rc16_level",   {5'd0, fifo_level}, 8'h00);
        start = 1'b1; stop = 1'b1;
        waitEdges(1);
        start = 1'b0; stop = 1'b0;
        waitEdges(1);
        checkOutput("error_holds_health",  {7'd0, health_err}, 8'h01);
        checkOutput("error_holds_trng_en", {7'd0, trng_en},    8'h00);
        clr_err = 1'b1;
        waitEdges(1);
        clr_err = 1'b0;
        checkOutput("clr_err_health", {7'd0, health_err}, 8'h00);

        $display("[TB] fill FIFO, stall, resume, stop mid-byte");
        streamBits = 64'h0000_006A_C12E_935C;
        pulseStart();
        applyStimulus(40);
        waitEdges(6);
        checkOutput("full_level",   {5'd0, fifo_level}, 8'h04);
        checkOutput("full_trng_en", {7'd0, trng_en},    8'h01);
        checkOutput("full_busy",    {7'd0, busy},       8'h01);
        checkOutput("full_head",    rnd_data,           8'h5C);
        pulsePop();
        checkOutput("pop_full_level", {5'd0, fifo_level}, 8'h03);
        checkOutput("pop_full_head",  rnd_data,           8'h93);
        waitEdges(1);
        checkOutput("held_byte_push_level", {5'd0, fifo_level}, 8'h04);
        pulsePop();
        checkOutput("second_pop_level", {5'd0, fifo_level}, 8'h03);
        waitEdges(6);
        pulseStop();
        checkOutput("stop_busy",    {7'd0, busy},       8'h00);
        checkOutput("stop_trng_en", {7'd0, trng_en},    8'h00);
        checkOutput("stop_level",   {5'd0, fifo_level}, 8'h03);
        checkOutput("stop_head0",   rnd_data,           8'h2E);
        pulsePop();
        checkOutput("stop_head1", rnd_data, 8'hC1);
        pulsePop();
        checkOutput("stop_head2", rnd_data, 8'h6A);
        pulsePop();
        checkOutput("drained_level", {5'd0, fifo_level}, 8'h00);

        streamBits = 64'h3D;
        pulseStart();
        applyStimulus(8);
        waitEdges(1);
        checkOutput("fresh_byte_level", {5'd0, fifo_level}, 8'h01);
        checkOutput("fresh_byte_data",  rnd_data,           8'h3D);
        pulseStop();
        pulsePop();

        $display("[TB] reset mid-SAMPLE with two bytes buffered");
        streamBits = 64'hD247;
        pulseStart();
        applyStimulus(16);
        waitEdges(1);
        checkOutput("pre_reset_level", {5'd0, fifo_level}, 8'h02);
        checkOutput("pre_reset_head",  rnd_data,           8'h47);
        rst_n = 1'b0;
        #1;
        checkOutput("mid_reset_trng_en", {7'd0, trng_en},    8'h00);
        checkOutput("mid_reset_busy",    {7'd0, busy},       8'h00);
        checkOutput("mid_reset_valid",   {7'd0, rnd_valid},  8'h00);
        checkOutput("mid_reset_data",    rnd_data,           8'h00);
        checkOutput("mid_reset_level",   {5'd0, fifo_level}, 8'h00);
        waitEdges(2);
        rst_n = 1'b1;
        waitEdges(2);
        checkOutput("post_reset_level",   {5'd0, fifo_level}, 8'h00);
        checkOutput("post_reset_trng_en", {7'd0, trng_en},    8'h00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
